// File: rtl/stopwatch_display_scan.sv
// stopwatch_display_scan
// Time-multiplexes the stopwatch BCD digits onto one common-anode 7-segment bus.
// A snapshot of the live digits is taken only at a scan-frame boundary, so a frame
// never shows a half-updated value. FREEZE holds that snapshot for a lap display.
// The TRG_IN rising edge toggles the seconds indicator on the decimal point of slot
// DP_DIGIT.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module stopwatch_display_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DP_DIGIT   = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [4*NUM_DIGITS-1:0]       DIGITS,
  input  logic                          TRG_IN,
  input  logic                          FREEZE,
  output logic [6:0]                    SEG,
  output logic                          DP,
  output logic [NUM_DIGITS-1:0]         AN,
  output logic [$clog2(NUM_DIGITS)-1:0] DIGIT_IDX
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = $clog2(SCAN_DIV);

  logic [PRE_W-1:0]        prescaler;
  logic                    tick;
  logic                    last_slot;
  logic [4*NUM_DIGITS-1:0] snapshot;
  logic                    dp_state;
  logic                    trg_prev;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [NUM_DIGITS-1:0]   an_next;

  // BCD to active-high {g..a}; codes 10..15 light only the middle bar.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign tick      = (prescaler == PRE_W'(SCAN_DIV - 1));
  assign last_slot = (DIGIT_IDX == IDX_W'(NUM_DIGITS - 1));

  // Slot-rate prescaler and scan position.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prescaler <= '0;
      DIGIT_IDX <= '0;
    end else if (tick) begin
      prescaler <= '0;
      DIGIT_IDX <= last_slot ? '0 : DIGIT_IDX + IDX_W'(1);
    end else begin
      prescaler <= prescaler + PRE_W'(1);
      DIGIT_IDX <= DIGIT_IDX;
    end
  end

  // Snapshot capture only at the frame boundary, skipped while frozen.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snapshot <= '0;
    end else if (tick && last_slot && !FREEZE) begin
      snapshot <= DIGITS;
    end else begin
      snapshot <= snapshot;
    end
  end

  // Seconds indicator toggles once per TRG_IN rising edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      trg_prev <= 1'b0;
      dp_state <= 1'b0;
    end else begin
      trg_prev <= TRG_IN;
      dp_state <= (TRG_IN && !trg_prev) ? !dp_state : dp_state;
    end
  end

  // Per-slot blank flags: a slot is dark when it and every higher digit are zero.
  always_comb begin
    blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      if (snapshot[4*k +: 4] != 4'd0) begin
        break;
      end else begin
        blank[k] = 1'b1;
      end
    end
`endif
  end

  // Next display drive for the slot currently selected.
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an_next   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (DIGIT_IDX == IDX_W'(k)) begin
        cur_digit  = snapshot[4*k +: 4];
        cur_blank  = blank[k];
        an_next[k] = blank[k];
      end else begin
        an_next[k] = 1'b1;
      end
    end
    if (cur_blank) begin
      seg_next = 7'h7F;
      dp_next  = 1'b1;
    end else begin
      seg_next = ~bcd_to_seg(cur_digit);
      dp_next  = (DIGIT_IDX == IDX_W'(DP_DIGIT)) ? !dp_state : 1'b1;
    end
  end

  // Registered pin drive; dark while in reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SEG <= 7'h7F;
      DP  <= 1'b1;
      AN  <= '1;
    end else begin
      SEG <= seg_next;
      DP  <= dp_next;
      AN  <= an_next;
    end
  end

endmodule
